// File: rtl/memory_sp_arb_pkg.sv
// Shared types and constants for the two-requester single-port memory arbiter.
package memory_sp_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef logic req_id_t;

endpackage

// File: rtl/memory_if.sv
// Single-port memory connection: read_data is valid the cycle after an enabled read.
interface memory_if #(
    parameter int  ADDR_W = 1,
    parameter type data_t = logic [1:0]
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    data_t             write_data;
    data_t             read_data;

    modport src (output enable, output wr_en, output addr, output write_data, input read_data);
    modport mem (input enable, input wr_en, input addr, input write_data, output read_data);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only on a completed handshake.
module rr_arb2
    import memory_sp_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [NUM_REQ-1:0] handshake,
    output logic [NUM_REQ-1:0] grant
);
    req_id_t last_q, last_d;

    always_comb begin
        grant = eligible;
        // On a conflict the requester that did not win last time goes first.
        if (&eligible) begin
            grant = (last_q == 1'b1) ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (|handshake) begin
            last_d = req_id_t'(handshake[1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/memory_sp_arb.sv
// Shares one single-port memory between two requesters with per-requester read response buffers.
module memory_sp_arb
    import memory_sp_arb_pkg::*;
#(
    parameter int  DEPTH  = 2,
    parameter type data_t = logic [1:0],
    parameter int  ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wr_en,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  data_t                          req_wdata [NUM_REQ],
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output data_t                          rsp_data [NUM_REQ],
    memory_if.src                          mem_port
);
    logic               inflight_q, inflight_d;
    req_id_t            inflight_id_q, inflight_id_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    data_t              rsp_data_q [NUM_REQ];
    data_t              rsp_data_d [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] handshake;
    req_id_t            gnt_id;

    // A read may only issue when its response slot will be free by the time data returns.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] &
            (req_wr_en[gi] |
             (!(inflight_q && (inflight_id_q == req_id_t'(gi))) &&
              (!rsp_valid_q[gi] || rsp_ready[gi])));
    end

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .eligible  (eligible),
        .handshake (handshake),
        .grant     (grant)
    );

    assign req_ready = grant & {NUM_REQ{rst_n}};
    assign handshake = req_valid & req_ready;
    assign gnt_id    = req_id_t'(handshake[1]);

    always_comb begin
        mem_port.enable     = |handshake;
        mem_port.wr_en      = 1'b0;
        mem_port.addr       = '0;
        mem_port.write_data = '0;
        if (|handshake) begin
            mem_port.wr_en      = req_wr_en[gnt_id];
            mem_port.addr       = req_addr[gnt_id];
            mem_port.write_data = req_wdata[gnt_id];
        end
    end

    always_comb begin
        inflight_d    = |(handshake & ~req_wr_en);
        inflight_id_d = gnt_id;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_valid_q[i] & ~rsp_ready[i];
            rsp_data_d[i]  = rsp_data_q[i];
            if (inflight_q && (inflight_id_q == req_id_t'(i))) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = mem_port.read_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_id_q <= 1'b0;
            rsp_valid_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
            rsp_valid_q   <= rsp_valid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_data_q[i] <= rsp_data_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_memory_sp_arb.sv
// Directed bench for memory_sp_arb with a reference memory and per-requester response scoreboards.
module tb_memory_sp_arb;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_wr_en;
    logic [1:0][0:0]  req_addr;
    logic [1:0]       req_wdata [2];
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_data [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] mem [2];
    logic [1:0] ref_mem [2];
    logic [1:0] exp_q [2][$];
    int         due_q [2][$];
    logic [1:0] prev_valid = '0;
    logic [1:0] prev_acc   = '0;

    memory_if #(.ADDR_W(1), .data_t(logic [1:0])) mem_if ();

    memory_sp_arb #(.DEPTH(2), .data_t(logic [1:0])) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr_en (req_wr_en),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_port  (mem_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_if.enable) begin
            if (mem_if.wr_en) mem[mem_if.addr] <= mem_if.write_data;
            else              mem_if.read_data <= mem[mem_if.addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: response timing/data against the scoreboard, then log this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = '0;
            prev_acc   = '0;
        end else begin
            chk("one_grant", {31'd0, $countones(req_ready) <= 1}, 1);
            chk("mem_enable", mem_if.enable, |(req_valid & req_ready));
            for (int i = 0; i < 2; i++) begin
                logic fresh;
                logic due_hit;
                fresh   = rsp_valid[i] && (!prev_valid[i] || prev_acc[i]);
                due_hit = (due_q[i].size() > 0) && (due_q[i][0] == cyc);
                chk($sformatf("rsp_timing%0d", i), fresh, due_hit);
                if (due_hit) void'(due_q[i].pop_front());
                if (rsp_valid[i]) begin
                    chk($sformatf("rsp_expected%0d", i), {31'd0, exp_q[i].size() > 0}, 1);
                    if (exp_q[i].size() > 0) begin
                        chk($sformatf("rsp_data%0d", i), rsp_data[i], exp_q[i][0]);
                        if (rsp_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_wr_en[i]) begin
                        ref_mem[req_addr[i]] = req_wdata[i];
                        $display("cycle %0d: req%0d write addr %0d data %0h", cyc, i, req_addr[i], req_wdata[i]);
                    end else begin
                        exp_q[i].push_back(ref_mem[req_addr[i]]);
                        due_q[i].push_back(cyc + 2);
                        $display("cycle %0d: req%0d read addr %0d expect %0h", cyc, i, req_addr[i], ref_mem[req_addr[i]]);
                    end
                end
            end
            prev_valid = rsp_valid;
            prev_acc   = rsp_valid & rsp_ready;
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_n        = 1'b0;
        req_valid    = 2'b11;
        req_wr_en    = 2'b00;
        req_addr     = '0;
        req_wdata[0] = 2'b00;
        req_wdata[1] = 2'b00;
        rsp_ready    = 2'b11;

        // Reset state with requests pending
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_mem_enable", mem_if.enable, 0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data0", rsp_data[0], 2'b00);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 2'b00;

        // req1 writes addr 0, req0 writes addr 1, req1 reads addr 1
        @(posedge clk); #1;
        req_valid = 2'b10; req_wr_en = 2'b10; req_addr[1] = 1'b0; req_wdata[1] = 2'b01;
        @(negedge clk);
        chk("wr1_ready", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b01; req_wr_en = 2'b01; req_addr[0] = 1'b1; req_wdata[0] = 2'b10;
        @(negedge clk);
        chk("wr0_ready", req_ready, 2'b01);
        chk("wr0_we", mem_if.wr_en, 1);
        chk("wr0_addr", mem_if.addr, 1);
        chk("wr0_wdata", mem_if.write_data, 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b10; req_wr_en = 2'b00; req_addr[1] = 1'b1;
        @(negedge clk);
        chk("rd1_ready", req_ready, 2'b10);
        chk("rd1_we", mem_if.wr_en, 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rd1_lat_early", rsp_valid[1], 0);
        chk("idle_addr", mem_if.addr, 0);
        @(negedge clk);
        chk("rd1_lat_valid", rsp_valid[1], 1);
        chk("rd1_data", rsp_data[1], 2'b10);
        repeat (3) @(posedge clk);
        #1;

        // Both read every cycle: alternate grants, memory busy every cycle
        req_valid = 2'b11; req_addr[0] = 1'b0; req_addr[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("alt_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_enable", mem_if.enable, 1);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // req0 response held off; second read blocked until accept
        rsp_ready = 2'b10; req_valid = 2'b01; req_addr[0] = 1'b0;
        @(negedge clk);
        chk("hold_first_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_addr[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_blocked", req_ready[0], 0);
            if (k >= 1) begin
                chk("hold_valid", rsp_valid[0], 1);
                chk("hold_data", rsp_data[0], 2'b01);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("accept_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("b2b_gap", rsp_valid[0], 0);
        @(negedge clk);
        chk("b2b_valid", rsp_valid[0], 1);
        chk("b2b_data", rsp_data[0], 2'b10);
        repeat (2) @(posedge clk);
        #1;

        // Reset the cycle after a read grant
        req_valid = 2'b10; req_addr[1] = 1'b1;
        @(negedge clk);
        chk("rst_rd_grant", req_ready, 2'b10);
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            due_q[i].delete();
        end
        @(negedge clk);
        chk("midrst_ready", req_ready, 2'b00);
        chk("midrst_enable", mem_if.enable, 0);
        chk("midrst_valid", rsp_valid, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_valid", rsp_valid, 2'b00);
        end
        @(posedge clk); #1;
        req_valid = 2'b11; req_addr[0] = 1'b0; req_addr[1] = 1'b1;
        @(negedge clk);
        chk("postrst_conflict", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("drain0", exp_q[0].size(), 0);
        chk("drain1", exp_q[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
